// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for LEGv8 with
//               memory handshake timeouts and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [10:0]      inst31_21,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_load,
   output logic             dmem_req,
   output logic             reg_wr_en,
   output logic             pc_write,
   output logic             pc_src,
   output logic [2:0]       phase,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t           r_state;
   logic [TW-1:0]    r_wait;
   logic             r_error;
   logic [CNT_W-1:0] r_retired;

   logic w_halt, w_nop, w_ldur, w_stur, w_rtype, w_addi;
   logic w_cbz, w_cbnz, w_b, w_branch, w_mem_op, w_exec_op, w_timeout;

   always_comb begin
      w_halt    = (inst31_21 == 11'h7FF);
      w_nop     = (inst31_21 == 11'h6A8);
      w_ldur    = (inst31_21 == 11'h7C2);
      w_stur    = (inst31_21 == 11'h7C0);
      w_rtype   = (inst31_21 == 11'h458) || (inst31_21 == 11'h658) ||
                  (inst31_21 == 11'h450) || (inst31_21 == 11'h550);
      w_addi    = (inst31_21[10:1] == 10'h244);
      w_cbz     = (inst31_21[10:3] == 8'hB4);
      w_cbnz    = (inst31_21[10:3] == 8'hB5);
      w_b       = (inst31_21[10:5] == 6'h05);
      w_branch  = w_cbz || w_cbnz || w_b;
      w_mem_op  = w_ldur || w_stur;
      w_exec_op = w_mem_op || w_rtype || w_addi || w_branch;
      // The last tolerated wait cycle; a ready arriving in it is still accepted.
      w_timeout = (r_wait == TW'(TIMEOUT - 1));
   end

   always_comb begin
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      dmem_req  = 1'b0;
      reg_wr_en = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      case (r_state)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready;
         end
         S_DECODE: pc_write = w_nop;
         S_EXEC: begin
            pc_write = w_branch;
            pc_src   = w_b || (w_cbz && zero) || (w_cbnz && !zero);
         end
         S_MEM: begin
            dmem_req = 1'b1;
            pc_write = dmem_ready && w_stur;
         end
         S_WB: begin
            reg_wr_en = 1'b1;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wait    <= '0;
         r_error   <= 1'b0;
         r_retired <= '0;
      end else begin
         if (pc_write)
            r_retired <= r_retired + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_FETCH;
                  r_wait  <= '0;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  r_state <= S_DECODE;
               end else if (w_timeout) begin
                  r_state <= S_HALT;
                  r_error <= 1'b1;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_DECODE: begin
               if (w_halt) begin
                  r_state <= S_HALT;
               end else if (w_nop) begin
                  r_state <= S_FETCH;
                  r_wait  <= '0;
               end else if (w_exec_op) begin
                  r_state <= S_EXEC;
               end else begin
                  r_state <= S_HALT;
                  r_error <= 1'b1;
               end
            end
            S_EXEC: begin
               r_wait <= '0;
               if (w_branch)
                  r_state <= S_FETCH;
               else if (w_mem_op)
                  r_state <= S_MEM;
               else
                  r_state <= S_WB;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_state <= w_stur ? S_FETCH : S_WB;
                  r_wait  <= '0;
               end else if (w_timeout) begin
                  r_state <= S_HALT;
                  r_error <= 1'b1;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_WB: begin
               r_state <= S_FETCH;
               r_wait  <= '0;
            end
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_HALT;
         endcase
      end
   end

   assign phase   = r_state;
   assign halted  = (r_state == S_HALT);
   assign error   = r_error;
   assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Randomized scoreboard bench for cpu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_sequencer;

   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 4;
   localparam int K_R = 0, K_ADDI = 1, K_LDUR = 2, K_STUR = 3, K_CBZ = 4;
   localparam int K_CBNZ = 5, K_B = 6, K_NOP = 7, K_HALT = 8, K_BAD = 9;

   logic             clk = 1'b0, rst = 1'b0, start = 1'b0, zero = 1'b0;
   logic             imem_ready = 1'b0, dmem_ready = 1'b0;
   logic [10:0]      inst31_21 = 11'h0;
   logic             imem_req, ir_load, dmem_req, reg_wr_en, pc_write, pc_src;
   logic             halted, error;
   logic [2:0]       phase;
   logic [CNT_W-1:0] retired;

   cpu_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .inst31_21(inst31_21), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
      .ir_load(ir_load), .dmem_req(dmem_req), .reg_wr_en(reg_wr_en),
      .pc_write(pc_write), .pc_src(pc_src), .phase(phase), .halted(halted),
      .error(error), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_halt; bit src; bit reg_wr; bit err;
      int lat; int dcnt; int ph; int ret;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;
   int   ret_model = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int classify(input logic [10:0] op);
      if (op == 11'h7FF) return K_HALT;
      if (op == 11'h6A8) return K_NOP;
      if (op == 11'h7C2) return K_LDUR;
      if (op == 11'h7C0) return K_STUR;
      if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
      if (op[10:1] == 10'h244) return K_ADDI;
      if (op[10:3] == 8'hB4) return K_CBZ;
      if (op[10:3] == 8'hB5) return K_CBNZ;
      if (op[10:5] == 6'h05) return K_B;
      return K_BAD;
   endfunction

   function automatic logic [10:0] gen_op(input int k);
      logic [10:0] r;
      r = 11'($urandom);
      case (k)
         K_R: begin
            case (r[1:0])
               2'd0:    return 11'h458;
               2'd1:    return 11'h658;
               2'd2:    return 11'h450;
               default: return 11'h550;
            endcase
         end
         K_ADDI: return {10'h244, r[0]};
         K_LDUR: return 11'h7C2;
         K_STUR: return 11'h7C0;
         K_CBZ:  return {8'hB4, r[2:0]};
         K_CBNZ: return {8'hB5, r[2:0]};
         K_B:    return {6'h05, r[4:0]};
         K_NOP:  return 11'h6A8;
         K_HALT: return 11'h7FF;
         default: begin
            while (classify(r) != K_BAD) r = 11'($urandom);
            return r;
         end
      endcase
   endfunction

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return TIMEOUT - 1;
      if (r < 6) return 0;
      return int'($urandom_range(1, 4));
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One cycle of stimulus; start is noise because every caller is outside IDLE.
   task automatic drive(input bit im, input bit dm, input bit z);
      imem_ready = im;
      dmem_ready = dm;
      zero       = z;
      start      = rb();
      cyc();
   endtask

   task automatic push_halt(input bit err);
      exp_t e;
      e.is_halt = 1'b1; e.src = 1'b0; e.reg_wr = 1'b0; e.err = err;
      e.lat = 0; e.dcnt = 0; e.ph = 6; e.ret = ret_model;
      sb.push_back(e);
   endtask

   task automatic run_instr(input logic [10:0] op, input int wi, input int wm, input bit z);
      int   k;
      exp_t e;
      k = classify(op);
      e.is_halt = 1'b0; e.src = 1'b0; e.reg_wr = 1'b0; e.err = 1'b0;
      e.lat = 0; e.dcnt = 0; e.ph = 0; e.ret = ret_model;
      case (k)
         K_NOP:        begin e.lat = wi + 2; e.ph = 2; end
         K_B:          begin e.lat = wi + 3; e.ph = 3; e.src = 1'b1; end
         K_CBZ:        begin e.lat = wi + 3; e.ph = 3; e.src = z; end
         K_CBNZ:       begin e.lat = wi + 3; e.ph = 3; e.src = !z; end
         K_R, K_ADDI:  begin e.lat = wi + 4; e.ph = 5; e.reg_wr = 1'b1; end
         K_STUR:       begin e.lat = wi + wm + 4; e.ph = 4; e.dcnt = wm + 1; end
         K_LDUR:       begin e.lat = wi + wm + 5; e.ph = 5; e.dcnt = wm + 1; e.reg_wr = 1'b1; end
         K_HALT:       begin e.is_halt = 1'b1; e.ph = 6; end
         default:      begin e.is_halt = 1'b1; e.ph = 6; e.err = 1'b1; end
      endcase
      sb.push_back(e);
      if (!e.is_halt) ret_model = (ret_model + 1) % (1 << CNT_W);
      inst31_21 = op;
      for (int i = 0; i < wi; i++) drive(1'b0, rb(), rb());
      drive(1'b1, rb(), rb());
      drive(rb(), rb(), rb());
      if (k == K_NOP || e.is_halt) return;
      drive(rb(), rb(), z);
      if (k == K_LDUR || k == K_STUR) begin
         for (int i = 0; i < wm; i++) drive(rb(), 1'b0, rb());
         drive(rb(), 1'b1, rb());
      end
      if (k == K_R || k == K_ADDI || k == K_LDUR) drive(rb(), rb(), rb());
   endtask

   task automatic imem_timeout();
      push_halt(1'b1);
      inst31_21 = gen_op(int'($urandom_range(0, 7)));
      for (int i = 0; i < TIMEOUT; i++) drive(1'b0, rb(), rb());
   endtask

   task automatic dmem_timeout();
      push_halt(1'b1);
      inst31_21 = rb() ? 11'h7C2 : 11'h7C0;
      drive(1'b1, rb(), rb());
      drive(rb(), rb(), rb());
      drive(rb(), rb(), rb());
      for (int i = 0; i < TIMEOUT; i++) drive(rb(), 1'b0, rb());
   endtask

   task automatic halt_tail();
      for (int i = 0; i < 5; i++) drive(rb(), rb(), rb());
      chk("halt_sticky", halted, 1);
      chk("halt_phase", phase, 6);
      chk("halt_no_imem_req", imem_req, 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic do_reset();
      #1;
      rst        = 1'b1;
      start      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      chk("rst_phase", phase, 0);
      chk("rst_retired", retired, 0);
      chk("rst_halted", halted, 0);
      chk("rst_error", error, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_ir_load", ir_load, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_reg_wr_en", reg_wr_en, 0);
      chk("rst_pc_write", pc_write, 0);
      chk("rst_pc_src", pc_src, 0);
      cyc();
      cyc();
      rst = 1'b0;
      ret_model = 0;
      sb.delete();
      cyc();
      chk("idle_hold", phase, 0);
   endtask

   task automatic begin_seg();
      do_reset();
      start = 1'b1;
      cyc();
   endtask

   // Monitor: pops one expectation per retirement or per entry into HALT.
   bit   active = 1'b0, prev_halted = 1'b0;
   int   lat = 0, dcnt = 0, lcnt = 0;
   exp_t me;

   always @(negedge clk) begin
      if (rst) begin
         active      = 1'b0;
         prev_halted = 1'b0;
      end else begin
         if (imem_req && !active) begin
            active = 1'b1; lat = 0; dcnt = 0; lcnt = 0;
         end
         if (active) begin
            lat++;
            if (dmem_req) dcnt++;
            if (ir_load)  lcnt++;
         end
         chk("stray_reg_wr", int'(reg_wr_en && !pc_write), 0);
         if (pc_write) begin
            if (sb.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               me = sb.pop_front();
               chk("retire_kind", 0, int'(me.is_halt));
               chk("retire_latency", lat, me.lat);
               chk("retire_pc_src", pc_src, me.src);
               chk("retire_reg_wr_en", reg_wr_en, me.reg_wr);
               chk("retire_dmem_cycles", dcnt, me.dcnt);
               chk("retire_ir_loads", lcnt, 1);
               chk("retire_phase", phase, me.ph);
               chk("retire_count", retired, me.ret);
            end
            active = 1'b0;
         end
         if (halted && !prev_halted) begin
            if (sb.size() == 0) begin
               chk("unexpected_halt", 1, 0);
            end else begin
               me = sb.pop_front();
               chk("halt_kind", 1, int'(me.is_halt));
               chk("halt_error", error, me.err);
               chk("halt_retired", retired, me.ret);
            end
            active = 1'b0;
         end
         if (halted)
            chk("halt_enables", int'({imem_req, ir_load, dmem_req, reg_wr_en, pc_write}), 0);
         prev_halted = halted;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, term;
      // Directed program: ADD, LDUR with 3 wait states, CBZ/CBNZ with zero=1.
      begin_seg();
      run_instr(11'h458, 0, 0, rb());
      run_instr(11'h7C2, 0, 3, rb());
      run_instr(11'h5A3, 0, 0, 1'b1);
      run_instr(11'h5AE, 0, 0, 1'b1);
      run_instr(11'h6A8, 0, 0, rb());
      run_instr(11'h7C0, 0, 0, rb());
      run_instr(11'h7FF, 0, 0, rb());
      halt_tail();
      chk("halt_op_no_error", error, 0);

      begin_seg();
      run_instr(11'h458, 0, 0, rb());
      run_instr(11'h000, 0, 0, rb());
      halt_tail();
      chk("bad_op_retired", retired, 1);

      begin_seg();
      run_instr(11'h0A5, TIMEOUT - 1, 0, rb());
      imem_timeout();
      halt_tail();

      // Abort in the middle of a data access.
      begin_seg();
      inst31_21 = 11'h7C2;
      drive(1'b1, rb(), rb());
      drive(rb(), rb(), rb());
      drive(rb(), rb(), rb());
      drive(rb(), 1'b0, rb());
      drive(rb(), 1'b0, rb());
      chk("mid_mem_phase", phase, 4);
      chk("mid_mem_dmem_req", dmem_req, 1);
      do_reset();

      for (int s = 0; s < 10; s++) begin
         begin_seg();
         n = int'($urandom_range(10, 24));
         for (int i = 0; i < n; i++)
            run_instr(gen_op(int'($urandom_range(0, 7))), pick_wait(), pick_wait(), rb());
         term = int'($urandom_range(0, 3));
         case (term)
            0:       run_instr(11'h7FF, pick_wait(), 0, rb());
            1:       run_instr(gen_op(K_BAD), pick_wait(), 0, rb());
            2:       imem_timeout();
            default: dmem_timeout();
         endcase
         halt_tail();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
